seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  - Time-multiplexed driver for an N-digit common-anode 7-segment display.
//  - Captures a packed hex word, decodes each nibble (0-F) to active-low GFEDCBA, scans anodes one digit at a time.
//  - Anti-ghost blanking at each digit-slot start; display updates only at frame boundaries (tear-free).
//  - Sits between datapath/register logic and the board display pins.
// PARAMETERS
//  - NUM_DIGITS    8       digits scanned; >= 2
//  - REFRESH_DIV   100000  clk cycles per digit slot; >= 4
//  - BLANK_CYCLES  4       cycles at slot start with all anodes off; 1 <= BLANK_CYCLES < REFRESH_DIV
// PORTS
//  - clk         in   1                     system clock, rising edge
//  - reset       in   1                     async, active-high
//  - value       in   4*NUM_DIGITS          hex nibbles; [3:0] = digit 0 (rightmost)
//  - dp_in       in   NUM_DIGITS            decimal point per digit, 1 = lit
//  - digit_en    in   NUM_DIGITS            per-digit enable, 0 = blank digit
//  - load        in   1                     1-cycle strobe: capture value/dp_in/digit_en
//  - seg         out  7                     GFEDCBA, active-low (0 = segment lit)
//  - dp          out  1                     decimal point, active-low
//  - an          out  NUM_DIGITS            anodes, active-low, at most one low
//  - digit_idx   out  $clog2(NUM_DIGITS)    digit currently driven
//  - frame_done  out  1                     1-cycle pulse when digit_idx wraps to 0
// BEHAVIOUR
//  - Reset (async assert, sync release): seg=7'h7F, dp=1, an=all 1s, digit_idx=0, frame_done=0,
//    prescaler=0, pending/active regs=0, pending_valid=0. Reset mid-scan forces these immediately.
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count: digit_idx increments
//    (NUM_DIGITS-1 -> 0). On that wrap only, frame_done=1 for exactly 1 cycle.
//  - load=1: value/dp_in/digit_en -> pending regs; pending_valid=1. Back-to-back loads: last wins.
//  - At frame boundary (idx wraps to 0): if pending_valid, pending -> active, pending_valid=0.
//    load in the same cycle as the wrap: new inputs go straight to active, pending_valid stays 0.
//  - No mid-frame change of displayed data, ever.
//  - Per slot: prescaler < BLANK_CYCLES -> an all 1s, seg=7'h7F, dp=1.
//    Otherwise an[digit_idx]=0, other an bits=1.
//  - Digit content: active nibble decoded; dp = ~active_dp[idx].
//    If active_en[idx]=0: seg=7'h7F, dp=1, anode still asserted (dark digit, uniform duty).
//  - Decode table (GFEDCBA): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010,
//    6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001,
//    E=0000110, F=0001110. Total case, no default path.
//  - Output timing: seg/dp/an registered; change 1 clk after the prescaler/idx update that selects them.
//  - Glitch-free: no combinational path from inputs to outputs.
// CONFIGURATION
//  - Macro SEG7_LEADING_ZERO_BLANK_EN.
//  - Defined: a digit k>0 is blanked (as digit_en=0) when active nibbles k..NUM_DIGITS-1 are all 0.
//    Digit 0 is never auto-blanked. dp still shown on auto-blanked digits if active_dp[k]=1.
//  - Not defined: zeros are displayed normally; logic absent from netlist.
// TESTING (bench params NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
//  - Reset high at arbitrary scan point -> same cycle: seg=7F, dp=1, an=4'b1111, digit_idx=0, frame_done=0.
//  - load value=16'h12AF, digit_en=4'hF, dp_in=4'b0100 -> after next wrap, idx0 seg=0001110,
//    idx1 seg=0001000, idx2 seg=0100100 dp=0, idx3 seg=1111001; an low 6 of every 8 cycles.
//  - load 16'h1234 mid-frame, then 16'h5678 before wrap -> old data until wrap, then 5678 only;
//    frame_done high 1 cycle every 32.
//  - load coincident with wrap cycle -> new data from digit 0 of that same frame.
//  - digit_en=4'b0101, value=16'h8888 -> idx1,idx3: seg=7F with an low; idx0,idx2: seg=0000000.
//  - value=16'h0050: with SEG7_LEADING_ZERO_BLANK_EN, idx3/idx2 seg=7F, idx1=0010010, idx0=1000000;
//    without it, idx3/idx2 = 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed hex driver for an N-digit common-anode 7-segment display.
// Latency : seg/dp/an registered, 1 clk after the prescaler/digit_idx state that selects them;
//           loaded data becomes visible at the next frame boundary (same frame if load hits the wrap).
// Backpr. : none; load is a single-cycle strobe that is always accepted, and the last load before a wrap wins.
// Option  : define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits (digit 0 never blanked).

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYCLES);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan timing state
  logic [PRE_W-1:0]      prescaler;
  logic                  slot_end;
  logic                  frame_wrap;

  // Double-buffered display data: pending is written by load, active feeds the decoder
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_en;
  logic                    pending_valid;
  logic [4*NUM_DIGITS-1:0] act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_en;

  // Per-digit view of the active data for the digit currently being scanned
  logic [3:0]            cur_nibble;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign slot_end   = (prescaler == PRE_LAST);
  assign frame_wrap = slot_end && (digit_idx == LAST_IDX);

  // GFEDCBA, active-low; every nibble value listed so the decode is a total case
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler and digit index; frame_done pulses on the cycle digit_idx returns to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler  <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (slot_end) begin
        prescaler <= '0;
        if (digit_idx == LAST_IDX) begin
          digit_idx  <= '0;
          frame_done <= 1'b1;
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  // Load into pending mid-frame; commit to active only at the frame wrap so a frame never tears.
  // A load landing exactly on the wrap bypasses pending and is shown from digit 0 onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value    <= '0;
      pend_dp       <= '0;
      pend_en       <= '0;
      pending_valid <= 1'b0;
      act_value     <= '0;
      act_dp        <= '0;
      act_en        <= '0;
    end else if (frame_wrap) begin
      pending_valid <= 1'b0;
      if (load) begin
        act_value <= value;
        act_dp    <= dp_in;
        act_en    <= digit_en;
      end else if (pending_valid) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_en    <= pend_en;
      end
    end else if (load) begin
      pend_value    <= value;
      pend_dp       <= dp_in;
      pend_en       <= digit_en;
      pending_valid <= 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Digit k>0 goes dark when it and every more-significant active nibble is zero
  always_comb begin
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (act_value[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_nibble = act_value[{digit_idx, 2'b00} +: 4];
  assign cur_en     = act_en[digit_idx];
  assign cur_dp     = act_dp[digit_idx];
  assign cur_lz     = lz_blank[digit_idx];
  assign an_sel     = ~(NUM_DIGITS'(1) << digit_idx);

  // Registered pin drive: blank at slot start against ghosting, then the selected digit.
  // A disabled digit keeps its anode on with all segments dark so every slot has equal duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
      an  <= '1;
    end else if (prescaler < BLANK_END) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      an <= an_sel;
      if (!cur_en) begin
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        seg <= cur_lz ? SEG_OFF : hex_to_seg(cur_nibble);
        dp  <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed-vector bench for seg7_scan_driver (4 digits, 8 clk per slot, 2 blank cycles).
// Stimulus pushes the hand-decoded expected digit for each future frame slot into a scoreboard;
// a negedge monitor pops an entry at the first lit cycle of each slot and compares.

module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    int         idx;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   frame_no = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input int fr, input int idx, input logic [6:0] s, input logic d, input string nm);
    exp_t e;
    e.frame = fr;
    e.idx   = idx;
    e.seg   = s;
    e.dp    = d;
    e.name  = nm;
    sb.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [3:0] prev_an = 4'hF;
  int         run_len = 0;
  bit         armed = 1'b0;
  int         cyc = 0;
  int         last_fd = -1;

  always @(negedge clk) begin
    int idx;
    cyc++;
    if (reset) begin
      armed   = 1'b0;
      run_len = 0;
      last_fd = -1;
      prev_an = an;
    end else begin
      if (frame_done) begin
        frame_no++;
        if (last_fd >= 0) check("frame_done_period", cyc - last_fd, 32);
        last_fd = cyc;
      end
      if (an == 4'hF) begin
        if (armed && run_len > 0) check("an_low_cycles_per_slot", run_len, 6);
        armed   = 1'b1;
        run_len = 0;
      end else begin
        if (armed) run_len++;
        if (prev_an == 4'hF) begin
          idx = -1;
          for (int i = 0; i < ND; i++) if (an[i] == 1'b0) idx = i;
          check("an_single_low", $countones(~an), 1);
          while (sb.size() > 0 && sb[0].frame < frame_no) begin
            checks++;
            errors++;
            $display("FAIL %s: slot frame %0d idx %0d never shown", sb[0].name, sb[0].frame, sb[0].idx);
            void'(sb.pop_front());
          end
          if (sb.size() > 0 && sb[0].frame == frame_no) begin
            check({sb[0].name, "_an_idx"},    idx,       sb[0].idx);
            check({sb[0].name, "_digit_idx"}, digit_idx, sb[0].idx);
            check({sb[0].name, "_seg"},       seg,       sb[0].seg);
            check({sb[0].name, "_dp"},        dp,        sb[0].dp);
            void'(sb.pop_front());
          end
        end
      end
      prev_an = an;
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync_frame(output int f);
    bit seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    #1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_sync: no frame_done within 100 cycles");
    end
    f = frame_no;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
    value    = v;
    digit_en = en;
    dp_in    = d;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Frame 1: nothing loaded yet, all digits disabled -> dark with anode on
    sync_frame(f);
    for (int i = 0; i < ND; i++) push(f, i, 7'h7F, 1'b1, "dark_after_reset");
    repeat (5) @(negedge clk);
    do_load(16'h12AF, 4'hF, 4'b0100);
    push(f + 1, 0, 7'b0001110, 1'b1, "h12AF_d0");
    push(f + 1, 1, 7'b0001000, 1'b1, "h12AF_d1");
    push(f + 1, 2, 7'b0100100, 1'b0, "h12AF_d2");
    push(f + 1, 3, 7'b1111001, 1'b1, "h12AF_d3");

    // Two loads inside one frame: old data holds, only the last load appears next frame
    sync_frame(f);
    repeat (4) @(negedge clk);
    do_load(16'h1234, 4'hF, 4'b0000);
    repeat (10) @(negedge clk);
    do_load(16'h5678, 4'hF, 4'b0000);
    push(f + 1, 0, 7'b0000000, 1'b1, "h5678_d0");
    push(f + 1, 1, 7'b1111000, 1'b1, "h5678_d1");
    push(f + 1, 2, 7'b0000010, 1'b1, "h5678_d2");
    push(f + 1, 3, 7'b0010010, 1'b1, "h5678_d3");

    // Load on the wrap cycle itself (31 cycles after frame_done), digits 1 and 3 disabled
    sync_frame(f);
    repeat (31) @(negedge clk);
    do_load(16'h8888, 4'b0101, 4'b0000);
    for (int k = 1; k <= 2; k++) begin
      push(f + k, 0, 7'b0000000, 1'b1, "wrapload_d0");
      push(f + k, 1, 7'h7F,      1'b1, "wrapload_d1_off");
      push(f + k, 2, 7'b0000000, 1'b1, "wrapload_d2");
      push(f + k, 3, 7'h7F,      1'b1, "wrapload_d3_off");
    end

    // Leading zeros, with a decimal point on the top digit
    sync_frame(f);
    sync_frame(f);
    repeat (5) @(negedge clk);
    do_load(16'h0050, 4'hF, 4'b1000);
    push(f + 1, 0, 7'b1000000, 1'b1, "h0050_d0");
    push(f + 1, 1, 7'b0010010, 1'b1, "h0050_d1");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    push(f + 1, 2, 7'h7F,      1'b1, "h0050_d2_lz");
    push(f + 1, 3, 7'h7F,      1'b0, "h0050_d3_lz_dp");
`else
    push(f + 1, 2, 7'b1000000, 1'b1, "h0050_d2");
    push(f + 1, 3, 7'b1000000, 1'b0, "h0050_d3_dp");
`endif

    // Asynchronous reset in the middle of a lit slot
    sync_frame(f);
    sync_frame(f);
    repeat (13) @(posedge clk);
    #3;
    check("pre_reset_an_lit", (an != 4'hF), 1);
    reset = 1'b1;
    #1;
    check("rst_async_seg",        seg,        7'h7F);
    check("rst_async_dp",         dp,         1'b1);
    check("rst_async_an",         an,         4'hF);
    check("rst_async_digit_idx",  digit_idx,  2'd0);
    check("rst_async_frame_done", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_hold_an",        an,        4'hF);
    check("rst_hold_digit_idx", digit_idx, 2'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: frame %0d idx %0d still pending at end", sb[0].name, sb[0].frame, sb[0].idx);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
